// File: rtl/core_dout_tx.sv
// core_dout_tx: queues EQUAL (match index) and BATCH_COMPLETE events and serialises them as nibble packets.
// Latency: an equal pulse in cycle t is pushed at the end of t, and N0 appears on core_dout at t+2 when idle and ready.
// Backpressure: a packet starts only while core_dout_ready=1; afterwards it waits for ready=0, counted from packet start.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   equal/equal_idx  one-cycle match pulse with its 16-bit index, pushed into the EQUAL queue
//   batch_complete   one-cycle pulse that sets the single pending-batch flag
//   core_dout_ready  receiver ready (high = a packet may start)
//   core_dout        registered nibble bus: 1, {00,EQ,BC}[, idx nibbles LSB first]; 0 when idle
//   busy             queue non-empty, batch pending or FSM not idle
//   err_overflow     sticky: equal arrived while the queue was full
//   err_batch        sticky: batch_complete arrived while one was already pending
module core_dout_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        equal,
    input  logic [15:0] equal_idx,
    input  logic        batch_complete,
    input  logic        core_dout_ready,
    output logic [3:0]  core_dout,
    output logic        busy,
    output logic        err_overflow,
    output logic        err_batch
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // EQUAL index queue
    // ------------------------------------------------------------------
    logic [15:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    // ------------------------------------------------------------------
    // Pending batch flag, sticky errors
    // ------------------------------------------------------------------
    logic batch_q, batch_d;
    logic err_ovf_q, err_ovf_d;
    logic err_bat_q, err_bat_d;

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;        // index of the nibble currently on the bus
    logic [3:0]  dout_q, dout_d;
    logic        eq_q, eq_d;          // latched header bits of the packet in flight
    logic        bc_q, bc_d;
    logic [15:0] idx_q, idx_d;
    logic        seen_low_q, seen_low_d;

    logic        start_pkt;
    logic        hdr_eq, hdr_bc;
    logic        batch_clr;
    logic [2:0]  cnt_next;
    logic [2:0]  last_nib;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    assign start_pkt = (state_q == IDLE) && core_dout_ready && (!fifo_empty || batch_q);

    // Header selection. BATCH_COMPLETE rides on an EQUAL packet only when
    // that EQUAL is the last one queued, so the batch marker can never
    // overtake an earlier match.
    assign hdr_eq = !fifo_empty;
    assign hdr_bc = fifo_empty ? batch_q
                               : (batch_q && (count_q == CW'(1)) && !equal);
    assign batch_clr = start_pkt && hdr_bc;

    assign pop  = start_pkt && !fifo_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = equal && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        batch_d   = (batch_q && !batch_clr) || batch_complete;
        err_ovf_d = err_ovf_q || (equal && fifo_full && !pop);
        err_bat_d = err_bat_q || (batch_complete && batch_q && !batch_clr);
    end

    assign cnt_next = cnt_q + 3'd1;
    assign last_nib = eq_q ? 3'd5 : 3'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = 4'h0;
        eq_d       = eq_q;
        bc_d       = bc_q;
        idx_d      = idx_q;
        seen_low_d = seen_low_q;

        case (state_q)
            IDLE: begin
                if (start_pkt) begin
                    state_d    = SEND;
                    cnt_d      = 3'd0;
                    dout_d     = 4'h1;
                    eq_d       = hdr_eq;
                    bc_d       = hdr_bc;
                    idx_d      = hdr_eq ? fifo_mem_q[rd_ptr_q] : 16'h0000;
                    seen_low_d = 1'b0;
                end
            end
            SEND: begin
                // The receiver normally drops ready while a long packet is
                // still being sent, so the drop is remembered here.
                if (!core_dout_ready) begin
                    seen_low_d = 1'b1;
                end
                if (cnt_q == last_nib) begin
                    state_d = WAIT_ACK;
                    dout_d  = 4'h0;
                end else begin
                    cnt_d = cnt_next;
                    case (cnt_next)
                        3'd1:    dout_d = {2'b00, eq_q, bc_q};
                        3'd2:    dout_d = idx_q[3:0];
                        3'd3:    dout_d = idx_q[7:4];
                        3'd4:    dout_d = idx_q[11:8];
                        3'd5:    dout_d = idx_q[15:12];
                        default: dout_d = 4'h0;
                    endcase
                end
            end
            WAIT_ACK: begin
                if (seen_low_q || !core_dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue storage carries no reset; entries are only read while counted.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= equal_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            batch_q    <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_bat_q  <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            dout_q     <= 4'h0;
            eq_q       <= 1'b0;
            bc_q       <= 1'b0;
            idx_q      <= 16'h0000;
            seen_low_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            batch_q    <= batch_d;
            err_ovf_q  <= err_ovf_d;
            err_bat_q  <= err_bat_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            eq_q       <= eq_d;
            bc_q       <= bc_d;
            idx_q      <= idx_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign core_dout    = dout_q;
    assign busy         = !fifo_empty || batch_q || (state_q != IDLE);
    assign err_overflow = err_ovf_q;
    assign err_batch    = err_bat_q;

endmodule

// File: tb/tb_core_dout_tx.sv
// tb_core_dout_tx: directed stimulus with a packet scoreboard for core_dout_tx.
// Latency: checks the two-cycle equal-to-N0 latency and every nibble of every packet.
// Backpressure: the receiver model drops ready 2 cycles after each N0, or ready is driven by hand.
module tb_core_dout_tx;

    typedef struct packed {
        logic [2:0]  len;
        logic [23:0] nibs;   // nibble k at [4k+3:4k]
    } pkt_t;

    logic        CLK;
    logic        RST;
    logic        equal;
    logic [15:0] equal_idx;
    logic        batch_complete;
    logic        core_dout_ready;
    logic [3:0]  core_dout;
    logic        busy;
    logic        err_overflow;
    logic        err_batch;

    logic        man_rdy;
    logic        auto_rdy;
    logic        rx_auto;

    int   tests;
    int   fails;
    int   cyc;
    int   n0_cyc;
    int   age;
    int   mon_st;
    int   mon_idx;
    pkt_t cur;
    pkt_t exp_q[$];

    assign core_dout_ready = rx_auto ? auto_rdy : man_rdy;

    core_dout_tx #(.FIFO_DEPTH(4)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .equal           (equal),
        .equal_idx       (equal_idx),
        .batch_complete  (batch_complete),
        .core_dout_ready (core_dout_ready),
        .core_dout       (core_dout),
        .busy            (busy),
        .err_overflow    (err_overflow),
        .err_batch       (err_batch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic eq, input logic bc, input logic [15:0] idx);
        pkt_t p;
        p.len  = eq ? 3'd6 : 3'd2;
        p.nibs = {idx, 2'b00, eq, bc, 4'h1};
        exp_q.push_back(p);
    endtask

    // Bus monitor and receiver model, evaluated once per cycle at the falling edge.
    task automatic mon_step();
        logic prev_rdy;
        prev_rdy = core_dout_ready;   // ready seen by the DUT in the previous cycle
        if (RST) begin
            mon_st   = 0;
            mon_idx  = 0;
            age      = 99;
            auto_rdy = 1'b1;
            return;
        end
        if (age < 99) age++;
        if (mon_st == 0) begin
            if (core_dout === 4'h1) begin
                n0_cyc = cyc;
                age    = 0;
                chk("n0_ready", {31'd0, prev_rdy}, 32'd1);
                chk("pkt_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    cur     = exp_q.pop_front();
                    mon_st  = 1;
                    mon_idx = 1;
                end
            end else begin
                chk("idle_bus", {28'd0, core_dout}, 32'd0);
            end
        end else begin
            if (mon_idx < int'(cur.len)) begin
                chk($sformatf("nib%0d", mon_idx), {28'd0, core_dout},
                    {28'd0, cur.nibs[mon_idx*4 +: 4]});
            end else begin
                chk("pkt_end", {28'd0, core_dout}, 32'd0);
                mon_st = 0;
            end
            mon_idx++;
        end
        auto_rdy = !(age == 2 || age == 3);
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        mon_step();
    endtask

    task automatic wait_done(input int budget, input logic need_idle, input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && mon_st == 0 && (!need_idle || busy === 1'b0))
               && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        tests = 0; fails = 0; cyc = 0; n0_cyc = 0; age = 99;
        mon_st = 0; mon_idx = 0; cur = '0;
        RST = 1'b1; equal = 1'b0; equal_idx = 16'h0; batch_complete = 1'b0;
        man_rdy = 1'b1; auto_rdy = 1'b1; rx_auto = 1'b0;

        // Reset state
        idle_ticks(3);
        chk("rst_dout", {28'd0, core_dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, err_overflow}, 32'd0);
        chk("rst_bat", {31'd0, err_batch}, 32'd0);
        RST = 1'b0;
        idle_ticks(2);

        // Single equal, hand-held ready: latency, nibbles, WAIT_ACK hold
        equal = 1'b1; equal_idx = 16'hA5C3;
        push_pkt(1'b1, 1'b0, 16'hA5C3);
        n = cyc;
        tick();
        equal = 1'b0;
        chk("t1_busy_q", {31'd0, busy}, 32'd1);
        wait_done(30, 1'b0, "t1_timeout");
        chk("t1_latency", n0_cyc - n, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_wait_ack_busy", {31'd0, busy}, 32'd1);
        end
        man_rdy = 1'b0;
        tick();
        chk("t1_busy_fall", {31'd0, busy}, 32'd0);
        man_rdy = 1'b1;
        rx_auto = 1'b1;
        idle_ticks(2);

        // batch_complete alone: short packet
        batch_complete = 1'b1;
        push_pkt(1'b0, 1'b1, 16'h0);
        tick();
        batch_complete = 1'b0;
        wait_done(40, 1'b1, "t2_timeout");

        // equal + batch_complete in the same cycle: one merged packet
        equal = 1'b1; equal_idx = 16'h0001; batch_complete = 1'b1;
        push_pkt(1'b1, 1'b1, 16'h0001);
        tick();
        equal = 1'b0; batch_complete = 1'b0;
        wait_done(40, 1'b1, "t3_timeout");
        chk("t3_ovf", {31'd0, err_overflow}, 32'd0);
        chk("t3_bat", {31'd0, err_batch}, 32'd0);

        // Three equals then batch: batch rides only on the last EQUAL
        rx_auto = 1'b0; man_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            equal = 1'b1; equal_idx = 16'(i);
            push_pkt(1'b1, (i == 3), 16'(i));
            tick();
        end
        equal = 1'b0;
        batch_complete = 1'b1;
        tick();
        batch_complete = 1'b0;
        idle_ticks(5);
        chk("t4_busy_held", {31'd0, busy}, 32'd1);
        rx_auto = 1'b1;
        wait_done(120, 1'b1, "t4_timeout");
        idle_ticks(10);

        // Overflow: five equals into a 4-deep queue with ready low
        rx_auto = 1'b0; man_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            equal = 1'b1; equal_idx = 16'h1000 + 16'(i);
            if (i < 4) push_pkt(1'b1, 1'b0, 16'h1000 + 16'(i));
            tick();
            if (i == 3) chk("t5_ovf_before", {31'd0, err_overflow}, 32'd0);
        end
        equal = 1'b0;
        chk("t5_ovf_set", {31'd0, err_overflow}, 32'd1);
        rx_auto = 1'b1;
        wait_done(200, 1'b1, "t5_timeout");
        idle_ticks(10);
        chk("t5_ovf_sticky", {31'd0, err_overflow}, 32'd1);

        // Two batch_complete pulses while ready low
        rx_auto = 1'b0; man_rdy = 1'b0;
        batch_complete = 1'b1;
        tick();
        batch_complete = 1'b0;
        chk("t6_bat_first", {31'd0, err_batch}, 32'd0);
        tick();
        batch_complete = 1'b1;
        tick();
        batch_complete = 1'b0;
        chk("t6_bat_set", {31'd0, err_batch}, 32'd1);
        push_pkt(1'b0, 1'b1, 16'h0);
        rx_auto = 1'b1;
        wait_done(40, 1'b1, "t6_timeout");
        idle_ticks(10);
        chk("t6_bat_sticky", {31'd0, err_batch}, 32'd1);

        // Reset while N3 of a long packet is on the bus
        equal = 1'b1; equal_idx = 16'hBEEF;
        push_pkt(1'b1, 1'b0, 16'hBEEF);
        tick();
        equal = 1'b0;
        n = 0;
        while (!(mon_st == 1 && mon_idx == 4) && n < 50) begin
            tick();
            n++;
        end
        chk("t7_reach_n3", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        RST = 1'b1;
        exp_q.delete();
        tick();
        chk("t7_dout", {28'd0, core_dout}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_ovf", {31'd0, err_overflow}, 32'd0);
        chk("t7_bat", {31'd0, err_batch}, 32'd0);
        RST = 1'b0;
        idle_ticks(10);
        chk("t7_busy_quiet", {31'd0, busy}, 32'd0);
        equal = 1'b1; equal_idx = 16'h1234;
        push_pkt(1'b1, 1'b0, 16'h1234);
        tick();
        equal = 1'b0;
        wait_done(40, 1'b1, "t7_timeout");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
